assoc_switch_predictor: RTL and testbench

// - Per-access miss classifier + associativity switch predictor for the mutative cache.
// - Shadow fully-associative tag directory (capacity-equivalent) splits real-cache misses into compulsory/conflict/capacity.
// - Weighted saturating counter votes; issues up/down associativity requests to cache control via valid/ready.
// - Successor adds: parametrised sizes/thresholds/weights, N setups, FIFO shadow replacement, flush, cooldown.

---
 rtl/assoc_switch_predictor.sv | 236 +++++++++++++++++++++++
 tb/tb_assoc_switch_predictor.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/assoc_switch_predictor.sv
// assoc_switch_predictor
// ----------------------
// Classifies every miss of the real (mutative) cache as a compulsory, conflict or
// capacity miss. It does this with a shadow fully-associative tag directory that
// has the same capacity as the real cache and uses FIFO replacement. A weighted
// saturating counter turns these classes into votes:
//   - conflict misses push towards more associativity;
//   - capacity misses push towards less associativity.
// When the counter crosses a threshold, a setup change request is raised to cache
// control through a valid/ready handshake. A cooldown window follows each
// accepted request.
//
// Ports
//   clk, rst         clock and synchronous active-high reset
//   acc_valid        one resolved cache access this cycle
//   acc_addr         byte address of that access
//   acc_hit          real cache hit for that access
//   flush            invalidate the whole shadow directory
//   setup_cur        associativity configuration currently in use
//   setup_valid      switch request pending (registered)
//   setup_up         1 = increase associativity, 0 = decrease; stable while valid
//   setup_ready      cache control accepts the request
//   dbg_ctr          switch counter
//   stat_*           32-bit event counters
//
// Build option: define ASSOC_PRED_STATS_EN to get the stat_* counters.
// When it is undefined, the stat_* ports are tied to zero.
module assoc_switch_predictor #(
  parameter int ADDR_W         = 32,
  parameter int OFFSET_BITS    = 5,
  parameter int SHADOW_ENTRIES = 64,
  parameter int NUM_SETUPS     = 4,
  parameter int CTR_W          = 8,
  parameter int CTR_INIT       = 30,
  parameter int UP_THRESH      = 45,
  parameter int DOWN_THRESH    = 15,
  parameter int CONFLICT_W     = 2,
  parameter int CAPACITY_W     = 1,
  parameter int COOLDOWN       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          acc_valid,
  input  logic [ADDR_W-1:0]             acc_addr,
  input  logic                          acc_hit,
  input  logic                          flush,
  input  logic [$clog2(NUM_SETUPS)-1:0] setup_cur,
  output logic                          setup_valid,
  output logic                          setup_up,
  input  logic                          setup_ready,
  output logic [CTR_W-1:0]              dbg_ctr,
  output logic [31:0]                   stat_hit,
  output logic [31:0]                   stat_conflict,
  output logic [31:0]                   stat_capacity,
  output logic [31:0]                   stat_compulsory,
  output logic [31:0]                   stat_switch
);
  localparam int TAG_W  = ADDR_W - OFFSET_BITS;
  localparam int IDX_W  = (SHADOW_ENTRIES > 1) ? $clog2(SHADOW_ENTRIES) : 1;
  localparam int COOL_W = (COOLDOWN > 1) ? $clog2(COOLDOWN + 1) : 1;

  typedef enum logic [1:0] {S_MON, S_REQ, S_COOL} state_t;

  state_t                    state_reg;
  logic [CTR_W-1:0]          ctr_reg;
  logic [COOL_W-1:0]         cool_cnt_reg;
  logic [TAG_W-1:0]          tag_reg [SHADOW_ENTRIES];
  logic [SHADOW_ENTRIES-1:0] valid_reg;
  logic [IDX_W-1:0]          ptr_reg;

  logic [TAG_W-1:0]          acc_tag;
  logic                      offset_unused;
  logic [SHADOW_ENTRIES-1:0] match_vec;
  logic                      shadow_hit_raw, shadow_full;
  logic                      shadow_hit, shadow_full_eff;
  logic [IDX_W-1:0]          free_idx, ins_idx;
  logic                      ins_en;
  logic                      ev_hit, ev_conflict, ev_capacity, ev_compulsory;
  logic [CTR_W:0]            ctr_sum;
  logic [CTR_W-1:0]          ctr_inc, ctr_dec;
  logic                      at_up, at_down, can_up, can_down, handshake;

  assign acc_tag       = acc_addr[ADDR_W-1:OFFSET_BITS];
  assign offset_unused = ^acc_addr[OFFSET_BITS-1:0];

  // Fully associative lookup: one tag comparator per shadow entry.
  genvar gi;
  generate
    for (gi = 0; gi < SHADOW_ENTRIES; gi++) begin : g_cmp
      assign match_vec[gi] = valid_reg[gi] && (tag_reg[gi] == acc_tag);
    end
  endgenerate

  assign shadow_hit_raw = |match_vec;
  assign shadow_full    = &valid_reg;

  // A flush in the same cycle makes the directory look empty to this access.
  // As a result, the access is classified as compulsory and is not inserted.
  assign shadow_hit      = shadow_hit_raw & ~flush;
  assign shadow_full_eff = shadow_full & ~flush;

  // Find the lowest-numbered invalid entry.
  always_comb begin
    free_idx = '0;
    for (int i = SHADOW_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_reg[i]) free_idx = IDX_W'(i);
    end
  end

  assign ins_en  = acc_valid & ~flush & ~shadow_hit_raw;
  assign ins_idx = shadow_full ? ptr_reg : free_idx;

  assign ev_hit        = acc_valid & acc_hit;
  assign ev_conflict   = acc_valid & ~acc_hit & shadow_hit;
  assign ev_capacity   = acc_valid & ~acc_hit & ~shadow_hit & shadow_full_eff;
  assign ev_compulsory = acc_valid & ~acc_hit & ~shadow_hit & ~shadow_full_eff;

  // The FIFO pointer only advances while the directory is full.
  // Until then, inserts fill the holes from the bottom up.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_reg <= '0;
      ptr_reg   <= '0;
    end else if (ins_en) begin
      valid_reg[ins_idx] <= 1'b1;
      if (shadow_full) ptr_reg <= ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ins_en) tag_reg[ins_idx] <= acc_tag;
  end

  // Saturating counter arithmetic. The extra carry bit detects overflow.
  assign ctr_sum = {1'b0, ctr_reg} + (CTR_W+1)'(CONFLICT_W);
  assign ctr_inc = ctr_sum[CTR_W] ? {CTR_W{1'b1}} : ctr_sum[CTR_W-1:0];
  assign ctr_dec = ({1'b0, ctr_reg} < (CTR_W+1)'(CAPACITY_W)) ? '0
                                                               : ctr_reg - CTR_W'(CAPACITY_W);

  // The thresholds are compared at 32 bits. This keeps a threshold that is
  // wider than the counter unreachable, rather than letting it alias.
  assign at_up     = 32'(ctr_reg) >= UP_THRESH;
  assign at_down   = 32'(ctr_reg) <= DOWN_THRESH;
  assign can_up    = 32'(setup_cur) < NUM_SETUPS - 1;
  assign can_down  = setup_cur != '0;
  assign handshake = setup_valid & setup_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_MON;
      ctr_reg      <= CTR_W'(CTR_INIT);
      cool_cnt_reg <= '0;
      setup_valid  <= 1'b0;
      setup_up     <= 1'b0;
    end else begin
      case (state_reg)
        S_MON: begin
          // In a threshold cycle, the counter restarts and that cycle's access event is dropped.
          if (at_up) begin
            ctr_reg <= CTR_W'(CTR_INIT);
            if (can_up) begin
              state_reg   <= S_REQ;
              setup_valid <= 1'b1;
              setup_up    <= 1'b1;
            end
          end else if (at_down) begin
            ctr_reg <= CTR_W'(CTR_INIT);
            if (can_down) begin
              state_reg   <= S_REQ;
              setup_valid <= 1'b1;
              setup_up    <= 1'b0;
            end
          end else if (ev_conflict) begin
            ctr_reg <= ctr_inc;
          end else if (ev_capacity) begin
            ctr_reg <= ctr_dec;
          end
        end
        S_REQ: begin
          if (setup_ready) begin
            setup_valid <= 1'b0;
            if (COOLDOWN == 0) begin
              state_reg <= S_MON;
            end else begin
              state_reg    <= S_COOL;
              cool_cnt_reg <= COOL_W'(COOLDOWN);
            end
          end
        end
        S_COOL: begin
          if (cool_cnt_reg <= COOL_W'(1)) state_reg <= S_MON;
          else cool_cnt_reg <= cool_cnt_reg - 1'b1;
        end
        default: state_reg <= S_MON;
      endcase
    end
  end

  assign dbg_ctr = ctr_reg;

`ifdef ASSOC_PRED_STATS_EN
  logic [31:0] stat_hit_reg, stat_conflict_reg, stat_capacity_reg;
  logic [31:0] stat_compulsory_reg, stat_switch_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hit_reg        <= '0;
      stat_conflict_reg   <= '0;
      stat_capacity_reg   <= '0;
      stat_compulsory_reg <= '0;
      stat_switch_reg     <= '0;
    end else begin
      if (ev_hit)        stat_hit_reg        <= stat_hit_reg + 32'd1;
      if (ev_conflict)   stat_conflict_reg   <= stat_conflict_reg + 32'd1;
      if (ev_capacity)   stat_capacity_reg   <= stat_capacity_reg + 32'd1;
      if (ev_compulsory) stat_compulsory_reg <= stat_compulsory_reg + 32'd1;
      if (handshake)     stat_switch_reg     <= stat_switch_reg + 32'd1;
    end
  end

  assign stat_hit        = stat_hit_reg;
  assign stat_conflict   = stat_conflict_reg;
  assign stat_capacity   = stat_capacity_reg;
  assign stat_compulsory = stat_compulsory_reg;
  assign stat_switch     = stat_switch_reg;
`else
  logic stats_unused;
  assign stats_unused    = ev_hit ^ ev_compulsory ^ handshake;
  assign stat_hit        = '0;
  assign stat_conflict   = '0;
  assign stat_capacity   = '0;
  assign stat_compulsory = '0;
  assign stat_switch     = '0;
`endif

endmodule

// File: tb/tb_assoc_switch_predictor.sv
// Testbench for assoc_switch_predictor.
// Each scenario task drives stimulus and checks its own results against:
//   - constants worked out from the classification and voting rules, or
//   - a behavioural model that tracks the shadow directory as an array of lines.
// A second instance with a 4-bit counter covers counter saturation.
`timescale 1ns/1ps
module tb_assoc_switch_predictor;
  logic        clk = 1'b0;
  logic        rst, acc_valid, acc_hit, flush, setup_ready;
  logic [31:0] acc_addr;
  logic [1:0]  setup_cur;
  logic        setup_valid, setup_up;
  logic [7:0]  dbg_ctr;
  logic [31:0] stat_hit, stat_conflict, stat_capacity, stat_compulsory, stat_switch;

  logic        sm_ready = 1'b0;
  logic        sm_valid, sm_up;
  logic [3:0]  sm_ctr;
  logic [31:0] sm_unused_hit, sm_unused_conf, sm_unused_cap, sm_unused_comp, sm_unused_sw;

  always #5 clk = ~clk;

`ifdef ASSOC_PRED_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  assoc_switch_predictor dut (
    .clk(clk), .rst(rst), .acc_valid(acc_valid), .acc_addr(acc_addr), .acc_hit(acc_hit),
    .flush(flush), .setup_cur(setup_cur), .setup_valid(setup_valid), .setup_up(setup_up),
    .setup_ready(setup_ready), .dbg_ctr(dbg_ctr), .stat_hit(stat_hit),
    .stat_conflict(stat_conflict), .stat_capacity(stat_capacity),
    .stat_compulsory(stat_compulsory), .stat_switch(stat_switch)
  );

  // Narrow counter: the up threshold can never be reached and the down threshold
  // sits at 0, so only saturation is visible.
  assoc_switch_predictor #(.CTR_W(4), .CTR_INIT(10), .DOWN_THRESH(0)) dut_small (
    .clk(clk), .rst(rst), .acc_valid(acc_valid), .acc_addr(acc_addr), .acc_hit(acc_hit),
    .flush(flush), .setup_cur(setup_cur), .setup_valid(sm_valid), .setup_up(sm_up),
    .setup_ready(sm_ready), .dbg_ctr(sm_ctr), .stat_hit(sm_unused_hit),
    .stat_conflict(sm_unused_conf), .stat_capacity(sm_unused_cap),
    .stat_compulsory(sm_unused_comp), .stat_switch(sm_unused_sw)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- behavioural model ----------------
  localparam int PH_MON = 0, PH_REQ = 1, PH_COOL = 2;
  logic [26:0] m_tag [64];
  bit          m_vld [64];
  int          m_ptr, m_ctr, m_phase, m_cool;
  bit          m_req, m_up;
  int          m_stat [5];   // hit, conflict, capacity, compulsory, switch

  function automatic void model_edge();
    bit sh, full;
    int free_i, cls, idx;
    if (rst) begin
      for (int i = 0; i < 64; i++) m_vld[i] = 0;
      for (int i = 0; i < 5; i++) m_stat[i] = 0;
      m_ptr = 0; m_ctr = 30; m_phase = PH_MON; m_cool = 0; m_req = 0; m_up = 0;
      return;
    end
    sh = 0; full = 1; free_i = -1;
    for (int i = 0; i < 64; i++) begin
      if (m_vld[i] && m_tag[i] == acc_addr[31:5]) sh = 1;
      if (!m_vld[i]) begin
        full = 0;
        if (free_i < 0) free_i = i;
      end
    end
    if (flush) begin sh = 0; full = 0; end
    cls = 0;
    if (acc_valid) cls = acc_hit ? 1 : (sh ? 2 : (full ? 3 : 4));
    if (cls != 0) m_stat[cls-1]++;
    if (flush) begin
      for (int i = 0; i < 64; i++) m_vld[i] = 0;
      m_ptr = 0;
    end else if (acc_valid && !sh) begin
      if (free_i >= 0) idx = free_i;
      else begin idx = m_ptr; m_ptr = (m_ptr + 1) % 64; end
      m_vld[idx] = 1;
      m_tag[idx] = acc_addr[31:5];
    end
    case (m_phase)
      PH_MON: begin
        if (m_ctr >= 45) begin
          if (setup_cur < 3) begin m_phase = PH_REQ; m_req = 1; m_up = 1; end
          m_ctr = 30;
        end else if (m_ctr <= 15) begin
          if (setup_cur > 0) begin m_phase = PH_REQ; m_req = 1; m_up = 0; end
          m_ctr = 30;
        end else if (cls == 2) m_ctr = (m_ctr + 2 > 255) ? 255 : m_ctr + 2;
        else if (cls == 3) m_ctr = (m_ctr < 1) ? 0 : m_ctr - 1;
      end
      PH_REQ: if (setup_ready) begin
        m_req = 0; m_stat[4]++; m_phase = PH_COOL; m_cool = 16;
      end
      default: begin
        m_cool--;
        if (m_cool == 0) m_phase = PH_MON;
      end
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_cycle(input bit v, input logic [31:0] a, input bit h, input bit f, input bit r);
    acc_valid = v; acc_addr = a; acc_hit = h; flush = f; setup_ready = r;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [31:0] line_addr(input int l);
    return (32'(l) << 5) | 32'($urandom_range(0, 31));
  endfunction

  task automatic pulse_rst();
    rst = 1'b1;
    do_cycle(0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic fill(input int first, input int last);
    for (int l = first; l <= last; l++) do_cycle(1, line_addr(l), 0, 0, 0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    do_cycle(0, 0, 0, 0, 0);
    do_cycle(0, 0, 0, 0, 1);
    rst = 1'b0;
    checks++; if (setup_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", setup_valid); end
    checks++; if (setup_up !== 1'b0) begin failures++; $display("FAIL reset_up: got %b want 0", setup_up); end
    checks++; if (dbg_ctr !== 8'd30) begin failures++; $display("FAIL reset_ctr: got %0d want 30", dbg_ctr); end
    checks++; if (sm_ctr !== 4'd10) begin failures++; $display("FAIL reset_small_ctr: got %0d want 10", sm_ctr); end
    checks++; if ((stat_hit | stat_conflict | stat_capacity | stat_compulsory | stat_switch) !== 32'd0) begin
      failures++; $display("FAIL reset_stats: got nonzero stat want 0");
    end
    do_cycle(1, $urandom, 0, 0, 0);
    checks++; if (dbg_ctr !== 8'd30) begin failures++; $display("FAIL reset_first_compulsory: ctr got %0d want 30", dbg_ctr); end
    checks++; if (stat_compulsory !== (STATS_ON ? 32'd1 : 32'd0)) begin
      failures++; $display("FAIL reset_first_class: stat_compulsory got %0d want %0d", stat_compulsory, STATS_ON);
    end
  endtask

  task automatic test_up_request();
    pulse_rst();
    setup_cur = 2'd1;
    fill(0, 3);
    checks++; if (dbg_ctr !== 8'd30) begin failures++; $display("FAIL up_fill_ctr: got %0d want 30", dbg_ctr); end
    for (int k = 1; k <= 8; k++) begin
      do_cycle(1, line_addr(k % 4), 0, 0, 0);
      checks++; if (dbg_ctr !== 8'(30 + 2 * k)) begin failures++; $display("FAIL up_conflict_ctr: k=%0d got %0d want %0d", k, dbg_ctr, 30 + 2 * k); end
    end
    checks++; if (setup_valid !== 1'b0) begin failures++; $display("FAIL up_valid_early: got %b want 0", setup_valid); end
    do_cycle(0, 0, 0, 0, 0);
    checks++; if (setup_valid !== 1'b1 || setup_up !== 1'b1) begin failures++; $display("FAIL up_request: valid=%b up=%b want 1 1", setup_valid, setup_up); end
    checks++; if (dbg_ctr !== 8'd30) begin failures++; $display("FAIL up_ctr_reinit: got %0d want 30", dbg_ctr); end
    for (int k = 0; k < 5; k++) begin
      do_cycle(1, line_addr(1), 0, 0, 0);
      checks++; if (setup_valid !== 1'b1 || setup_up !== 1'b1 || dbg_ctr !== 8'd30) begin
        failures++; $display("FAIL up_hold: cycle %0d valid=%b up=%b ctr=%0d want 1 1 30", k, setup_valid, setup_up, dbg_ctr);
      end
    end
    do_cycle(0, 0, 0, 0, 1);
    checks++; if (setup_valid !== 1'b0) begin failures++; $display("FAIL up_accept: valid got %b want 0", setup_valid); end
    for (int k = 0; k < 16; k++) begin
      do_cycle(1, line_addr(2), 0, 0, 1);
      checks++; if (dbg_ctr !== 8'd30 || setup_valid !== 1'b0) begin
        failures++; $display("FAIL up_cooldown: cycle %0d ctr=%0d valid=%b want 30 0", k, dbg_ctr, setup_valid);
      end
    end
    do_cycle(1, line_addr(2), 0, 0, 0);
    checks++; if (dbg_ctr !== 8'd32) begin failures++; $display("FAIL up_after_cool: ctr got %0d want 32", dbg_ctr); end
  endtask

  task automatic test_down_request();
    pulse_rst();
    setup_cur = 2'd2;
    fill(0, 63);
    for (int k = 1; k <= 15; k++) do_cycle(1, line_addr(63 + k), 0, 0, 0);
    checks++; if (dbg_ctr !== 8'd15) begin failures++; $display("FAIL down_ctr: got %0d want 15", dbg_ctr); end
    do_cycle(0, 0, 0, 0, 0);
    checks++; if (setup_valid !== 1'b1 || setup_up !== 1'b0 || dbg_ctr !== 8'd30) begin
      failures++; $display("FAIL down_request: valid=%b up=%b ctr=%0d want 1 0 30", setup_valid, setup_up, dbg_ctr);
    end
    do_cycle(0, 0, 0, 0, 1);
    for (int k = 0; k < 16; k++) do_cycle(0, 0, 0, 0, 0);
    setup_cur = 2'd0;
    for (int k = 1; k <= 15; k++) do_cycle(1, line_addr(99 + k), 0, 0, 0);
    checks++; if (dbg_ctr !== 8'd15) begin failures++; $display("FAIL down_min_ctr: got %0d want 15", dbg_ctr); end
    do_cycle(0, 0, 0, 0, 0);
    checks++; if (setup_valid !== 1'b0 || dbg_ctr !== 8'd30) begin
      failures++; $display("FAIL down_at_min: valid=%b ctr=%0d want 0 30", setup_valid, dbg_ctr);
    end
  endtask

  task automatic test_max_setup_saturate();
    int exp_main;
    int exp_small;
    pulse_rst();
    setup_cur = 2'd3;
    do_cycle(1, line_addr(0), 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      do_cycle(1, line_addr(0), 0, 0, 0);
      exp_main  = (k <= 8) ? 30 + 2 * k : (k == 9 ? 30 : 32);
      exp_small = (10 + 2 * k > 15) ? 15 : 10 + 2 * k;
      checks++; if (dbg_ctr !== 8'(exp_main) || setup_valid !== 1'b0) begin
        failures++; $display("FAIL max_setup: k=%0d ctr=%0d valid=%b want %0d 0", k, dbg_ctr, setup_valid, exp_main);
      end
      checks++; if (sm_ctr !== 4'(exp_small) || sm_valid !== 1'b0) begin
        failures++; $display("FAIL saturate: k=%0d ctr=%0d valid=%b want %0d 0", k, sm_ctr, sm_valid, exp_small);
      end
    end
  endtask

  task automatic test_flush();
    pulse_rst();
    setup_cur = 2'd1;
    fill(0, 63);
    do_cycle(1, line_addr(0), 0, 1, 0);
    checks++; if (dbg_ctr !== 8'd30) begin failures++; $display("FAIL flush_same_cycle: ctr got %0d want 30", dbg_ctr); end
    do_cycle(1, line_addr(0), 0, 0, 0);
    checks++; if (dbg_ctr !== 8'd30) begin failures++; $display("FAIL flush_reaccess: ctr got %0d want 30", dbg_ctr); end
    fill(1, 63);
    do_cycle(1, line_addr(100), 0, 0, 0);
    checks++; if (dbg_ctr !== 8'd29) begin failures++; $display("FAIL flush_65th: ctr got %0d want 29", dbg_ctr); end
    do_cycle(1, line_addr(0), 0, 0, 0);
    checks++; if (dbg_ctr !== 8'd28) begin failures++; $display("FAIL flush_evicted_idx0: ctr got %0d want 28", dbg_ctr); end
    do_cycle(1, line_addr(2), 0, 0, 0);
    checks++; if (dbg_ctr !== 8'd30) begin failures++; $display("FAIL flush_fifo_order: ctr got %0d want 30", dbg_ctr); end
  endtask

  task automatic test_stats();
    pulse_rst();
    setup_cur = 2'd1;
    do_cycle(1, line_addr(0), 0, 0, 0);
    for (int k = 0; k < 3; k++) do_cycle(1, line_addr(0), 1, 0, 0);
    for (int k = 0; k < 2; k++) do_cycle(1, line_addr(0), 0, 0, 0);
    fill(1, 63);
    do_cycle(1, line_addr(200), 0, 0, 0);
    for (int k = 0; k < 6; k++) do_cycle(1, line_addr(5), 0, 0, 0);
    checks++; if (dbg_ctr !== 8'd45) begin failures++; $display("FAIL stats_ctr: got %0d want 45", dbg_ctr); end
    do_cycle(0, 0, 0, 0, 0);
    do_cycle(0, 0, 0, 0, 1);
    checks++; if (stat_hit !== (STATS_ON ? 32'd3 : 32'd0)) begin failures++; $display("FAIL stat_hit: got %0d", stat_hit); end
    checks++; if (stat_conflict !== (STATS_ON ? 32'd8 : 32'd0)) begin failures++; $display("FAIL stat_conflict: got %0d", stat_conflict); end
    checks++; if (stat_capacity !== (STATS_ON ? 32'd1 : 32'd0)) begin failures++; $display("FAIL stat_capacity: got %0d", stat_capacity); end
    checks++; if (stat_compulsory !== (STATS_ON ? 32'd64 : 32'd0)) begin failures++; $display("FAIL stat_compulsory: got %0d", stat_compulsory); end
    checks++; if (stat_switch !== (STATS_ON ? 32'd1 : 32'd0)) begin failures++; $display("FAIL stat_switch: got %0d", stat_switch); end
  endtask

  task automatic test_rst_handshake();
    pulse_rst();
    setup_cur = 2'd1;
    fill(0, 3);
    for (int k = 1; k <= 8; k++) do_cycle(1, line_addr(k % 4), 0, 0, 0);
    do_cycle(0, 0, 0, 0, 0);
    checks++; if (setup_valid !== 1'b1) begin failures++; $display("FAIL rst_hs_pending: valid got %b want 1", setup_valid); end
    pulse_rst();
    checks++; if (setup_valid !== 1'b0 || setup_up !== 1'b0 || dbg_ctr !== 8'd30) begin
      failures++; $display("FAIL rst_hs_drop: valid=%b up=%b ctr=%0d want 0 0 30", setup_valid, setup_up, dbg_ctr);
    end
  endtask

  task automatic test_random();
    logic [31:0] got [5];
    int exp_s;
    pulse_rst();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 19) == 0) setup_cur = 2'($urandom_range(0, 3));
      do_cycle($urandom_range(0, 9) < 8, line_addr($urandom_range(0, 79)),
               $urandom_range(0, 9) < 3, $urandom_range(0, 199) == 0, $urandom_range(0, 9) < 3);
      checks++; if (dbg_ctr !== 8'(m_ctr) || setup_valid !== m_req || setup_up !== m_up) begin
        failures++; $display("FAIL random_state: n=%0d ctr=%0d valid=%b up=%b want %0d %b %b", n, dbg_ctr, setup_valid, setup_up, m_ctr, m_req, m_up);
      end
      got[0] = stat_hit; got[1] = stat_conflict; got[2] = stat_capacity;
      got[3] = stat_compulsory; got[4] = stat_switch;
      for (int s = 0; s < 5; s++) begin
        exp_s = STATS_ON ? m_stat[s] : 0;
        checks++; if (got[s] !== 32'(exp_s)) begin
          failures++; $display("FAIL random_stat%0d: n=%0d got %0d want %0d", s, n, got[s], exp_s);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; acc_valid = 1'b0; acc_addr = '0; acc_hit = 1'b0; flush = 1'b0;
    setup_ready = 1'b0; setup_cur = 2'd1;
    test_reset();
    test_up_request();
    test_down_request();
    test_max_setup_saturate();
    test_flush();
    test_stats();
    test_rst_handshake();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
